// File: rtl/pe_pkg.sv
// Shared writeback definitions for the PE datapath.
// Widths here match the register file defaults.
package pe_pkg;
   localparam int PE_DATA_W = 32;
   localparam int PE_ADDR_W = 5;

   localparam logic [PE_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                 live;
      logic [PE_ADDR_W-1:0] addr;
      logic [PE_DATA_W-1:0] data;
   } pe_wb_entry_t;
endpackage

// File: rtl/pe_wb_fifo.sv
// Circular MAC result buffer with per-entry live bits,
// address squash and associative pending-write lookup.
module pe_wb_fifo
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_W,
   parameter int ADDR_WIDTH = PE_ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [ADDR_WIDTH-1:0] push_addr_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   input  logic                  squash_i,
   input  logic [ADDR_WIDTH-1:0] squash_addr_i,
   input  logic [ADDR_WIDTH-1:0] chk_addr_i,
   output logic                  chk_hit_o,
   output logic                  head_live_o,
   output logic [ADDR_WIDTH-1:0] head_addr_o,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic [CNT_WIDTH-1:0]  count_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic                  live_q [FIFO_DEPTH];
   logic                  live_d [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_d [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_q, rd_d;
   logic [PTR_W-1:0]      wr_q, wr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   // Live bits are cleared on pop, so free slots never match a lookup.
   always_comb begin
      live_d  = live_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (squash_i && addr_q[i] == squash_addr_i) live_d[i] = 1'b0;
      end
      if (pop_i) begin
         live_d[rd_q] = 1'b0;
         rd_d         = rd_q + PTR_W'(1);
      end
      if (push_i) begin
         live_d[wr_q] = !(squash_i && push_addr_i == squash_addr_i);
         addr_d[wr_q] = push_addr_i;
         data_d[wr_q] = push_data_i;
         wr_d         = wr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_WIDTH'(push_i) - CNT_WIDTH'(pop_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         live_q  <= '{default: 1'b0};
         addr_q  <= '{default: '0};
         data_q  <= '{default: '0};
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         live_q  <= live_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      chk_hit_o = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (live_q[i] && addr_q[i] == chk_addr_i) chk_hit_o = 1'b1;
      end
      if (chk_addr_i == ADDR_WIDTH'(REG_ZERO)) chk_hit_o = 1'b0;
   end

   assign head_live_o = live_q[rd_q];
   assign head_addr_o = addr_q[rd_q];
   assign head_data_o = data_q[rd_q];
   assign count_o     = count_q;
   assign full_o      = (count_q == CNT_WIDTH'(FIFO_DEPTH));
   assign empty_o     = (count_q == '0);
endmodule

// File: rtl/pe_wb_arbiter.sv
// PE writeback: ALU-first merge of ALU and buffered MAC
// results onto the register file write port.
module pe_wb_arbiter
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_W,
   parameter int ADDR_WIDTH = PE_ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mac_valid,
   output logic                  mac_ready,
   input  logic [ADDR_WIDTH-1:0] mac_addr,
   input  logic [DATA_WIDTH-1:0] mac_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] chk_addr,
   output logic                  chk_hit,
   output logic [CNT_WIDTH-1:0]  fifo_count
);
   logic                  full, empty;
   logic                  push, pop, alu_wr, mac_wr;
   logic                  head_live;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   assign mac_ready = !rst && !full;
   assign push      = mac_valid && mac_ready &&
                      mac_addr != ADDR_WIDTH'(REG_ZERO);
   assign alu_wr    = alu_valid && alu_addr != ADDR_WIDTH'(REG_ZERO);
   // Any ALU slot, even to r0, blocks the pop.
   assign pop       = !alu_valid && !empty;
   assign mac_wr    = pop && head_live;

   pe_wb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_fifo (
      .clk_i         (clk),
      .rst_i         (rst),
      .push_i        (push),
      .push_addr_i   (mac_addr),
      .push_data_i   (mac_data),
      .pop_i         (pop),
      .squash_i      (alu_wr),
      .squash_addr_i (alu_addr),
      .chk_addr_i    (chk_addr),
      .chk_hit_o     (chk_hit),
      .head_live_o   (head_live),
      .head_addr_o   (head_addr),
      .head_data_o   (head_data),
      .count_o       (fifo_count),
      .full_o        (full),
      .empty_o       (empty)
   );

   always_comb begin
      wr_en_d   = alu_wr || mac_wr;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (alu_wr) begin
         wr_addr_d = alu_addr;
         wr_data_d = alu_data;
      end else if (mac_wr) begin
         wr_addr_d = head_addr;
         wr_data_d = head_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
endmodule

// File: tb/tb_pe_wb_arbiter.sv
// Directed scenario bench for pe_wb_arbiter.
module tb_pe_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_addr = '0;
   logic [31:0] alu_data = '0;
   logic        mac_valid = 1'b0;
   logic        mac_ready;
   logic [4:0]  mac_addr = '0;
   logic [31:0] mac_data = '0;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  chk_addr = '0;
   logic        chk_hit;
   logic [2:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   pe_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_addr   (alu_addr),
      .alu_data   (alu_data),
      .mac_valid  (mac_valid),
      .mac_ready  (mac_ready),
      .mac_addr   (mac_addr),
      .mac_data   (mac_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .chk_addr   (chk_addr),
      .chk_hit    (chk_hit),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      mac_valid = 1'b0;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d);
      alu_valid = 1'b1;
      alu_addr  = a;
      alu_data  = d;
   endtask

   task automatic mac(input logic [4:0] a, input logic [31:0] d);
      mac_valid = 1'b1;
      mac_addr  = a;
      mac_data  = d;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %0b exp 0", wr_en); end
      checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL rst_wr_addr got %0d exp 0", wr_addr); end
      checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data got %h exp 0", wr_data); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
      checks++; if (mac_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", mac_ready); end
      step();
      rst = 1'b0;
      #1;
      checks++; if (mac_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %0b exp 1", mac_ready); end
   endtask

   task automatic test_alu_single();
      alu(5'd3, 32'hDEADBEEF);
      step();
      idle();
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL alu_en got %0b exp 1", wr_en); end
      checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL alu_addr got %0d exp 3", wr_addr); end
      checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got %h exp deadbeef", wr_data); end
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL alu_en_off got %0b exp 0", wr_en); end
      checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL alu_hold got %0d exp 3", wr_addr); end
   endtask

   task automatic test_fifo_full();
      for (int i = 1; i <= 4; i++) begin
         alu(5'd20, 32'h2000 + i);
         mac(5'(i), 32'h100 + i);
         checks++; if (mac_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %0b exp 1", i, mac_ready); end
         step();
         checks++; if (wr_addr !== 5'd20 || wr_data !== 32'h2000 + i) begin errors++; $display("FAIL fill_alu%0d got %0d/%h exp 20/%h", i, wr_addr, wr_data, 32'h2000 + i); end
      end
      mac(5'd5, 32'h105);
      #1;
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", fifo_count); end
      checks++; if (mac_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", mac_ready); end
      alu_valid = 1'b0;
      step();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== 32'h101) begin errors++; $display("FAIL drain1 got %0b/%0d/%h exp 1/1/101", wr_en, wr_addr, wr_data); end
      checks++; if (fifo_count !== 3'd3 || mac_ready !== 1'b1) begin errors++; $display("FAIL drain1_cnt got %0d/%0b exp 3/1", fifo_count, mac_ready); end
      step();
      mac_valid = 1'b0;
      checks++; if (wr_addr !== 5'd2 || fifo_count !== 3'd3) begin errors++; $display("FAIL drain2 got %0d/%0d exp 2/3", wr_addr, fifo_count); end
      for (int i = 3; i <= 5; i++) begin
         step();
         checks++; if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'h100 + i) begin errors++; $display("FAIL drain%0d got %0b/%0d/%h exp 1/%0d/%h", i, wr_en, wr_addr, wr_data, i, 32'h100 + i); end
         checks++; if (fifo_count !== 3'(5 - i)) begin errors++; $display("FAIL drain%0d_cnt got %0d exp %0d", i, fifo_count, 5 - i); end
      end
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL drained_en got %0b exp 0", wr_en); end
   endtask

   task automatic test_priority();
      alu(5'd10, 32'hA0); mac(5'd8, 32'h80);
      step();
      checks++; if (wr_addr !== 5'd10 || wr_data !== 32'hA0) begin errors++; $display("FAIL pri1 got %0d/%h exp 10/a0", wr_addr, wr_data); end
      alu(5'd11, 32'hA1); mac(5'd9, 32'h90);
      step();
      checks++; if (wr_addr !== 5'd11) begin errors++; $display("FAIL pri2 got %0d exp 11", wr_addr); end
      mac_valid = 1'b0;
      alu(5'd12, 32'hA2);
      step();
      checks++; if (wr_addr !== 5'd12 || fifo_count !== 3'd2) begin errors++; $display("FAIL pri3 got %0d/%0d exp 12/2", wr_addr, fifo_count); end
      idle();
      step();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 32'h80) begin errors++; $display("FAIL pri4 got %0b/%0d/%h exp 1/8/80", wr_en, wr_addr, wr_data); end
      step();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h90) begin errors++; $display("FAIL pri5 got %0b/%0d/%h exp 1/9/90", wr_en, wr_addr, wr_data); end
      step();
      checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL pri6 got %0b/%0d exp 0/0", wr_en, fifo_count); end
   endtask

   task automatic test_squash();
      alu(5'd10, 32'h0); mac(5'd7, 32'h11);
      step();
      mac_valid = 1'b0;
      chk_addr = 5'd7;
      #1;
      checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL sq_hit_before got %0b exp 1", chk_hit); end
      alu(5'd7, 32'h22);
      step();
      idle();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h22) begin errors++; $display("FAIL sq_alu got %0b/%0d/%h exp 1/7/22", wr_en, wr_addr, wr_data); end
      checks++; if (chk_hit !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL sq_hit_after got %0b/%0d exp 0/1", chk_hit, fifo_count); end
      step();
      checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL sq_pop got %0b/%0d exp 0/0", wr_en, fifo_count); end
      alu(5'd6, 32'h66); mac(5'd6, 32'h60);
      chk_addr = 5'd6;
      step();
      idle();
      checks++; if (wr_addr !== 5'd6 || wr_data !== 32'h66 || fifo_count !== 3'd1) begin errors++; $display("FAIL sq_same got %0d/%h/%0d exp 6/66/1", wr_addr, wr_data, fifo_count); end
      checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL sq_same_hit got %0b exp 0", chk_hit); end
      step();
      checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL sq_same_pop got %0b/%0d exp 0/0", wr_en, fifo_count); end
   endtask

   task automatic test_reg_zero();
      alu(5'd0, 32'h55); mac(5'd0, 32'h77);
      chk_addr = 5'd0;
      #1;
      checks++; if (mac_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", mac_ready); end
      step();
      idle();
      checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL r0_wr got %0b/%0d exp 0/0", wr_en, fifo_count); end
      checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL r0_hit got %0b exp 0", chk_hit); end
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL r0_late got %0b exp 0", wr_en); end
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 3; i++) begin
         alu(5'd15, 32'hF0); mac(5'(i), 32'h300 + i);
         step();
      end
      mac_valid = 1'b0;
      chk_addr = 5'd2;
      #1;
      checks++; if (fifo_count !== 3'd3 || chk_hit !== 1'b1) begin errors++; $display("FAIL ar_pre got %0d/%0b exp 3/1", fifo_count, chk_hit); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (wr_en !== 1'b0 || fifo_count !== 3'd0 || mac_ready !== 1'b0) begin errors++; $display("FAIL ar_now got %0b/%0d/%0b exp 0/0/0", wr_en, fifo_count, mac_ready); end
      checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL ar_hit got %0b exp 0", chk_hit); end
      idle();
      step();
      rst = 1'b0;
      #1;
      checks++; if (mac_ready !== 1'b1 || fifo_count !== 3'd0) begin errors++; $display("FAIL ar_rel got %0b/%0d exp 1/0", mac_ready, fifo_count); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ar_stale%0d got %0b exp 0", i, wr_en); end
      end
   endtask

   initial begin
      test_reset();
      test_alu_single();
      test_fifo_full();
      test_priority();
      test_squash();
      test_reg_zero();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
